// File: rtl/cpu_pkg.sv
// Shared CPU types for the instruction prefetch queue.
// Optional build macro: IFQ_BYPASS_EN (zero-latency empty-queue bypass).
package cpu_pkg;

  localparam int IFQ_PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  typedef enum logic [0:0] {
    IFQ_FETCH = 1'b0,
    IFQ_DRAIN = 1'b1
  } ifq_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Generic ring buffer for prefetched {pc, inst} entries.
// Flush has priority over push and pop.
module ifq_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = ifq_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  T                         wdata,
  output T                         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: sequential fetch, DEPTH-entry buffer, redirect drain.
// Optional build macro: IFQ_BYPASS_EN (empty-queue completion shown same cycle).
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ic_req,
  output logic [ADDR_WIDTH-1:0]    ic_addr,
  input  logic                     ic_wait,
  input  logic [INST_WIDTH-1:0]    ic_rdata,
  input  logic                     redirect_i,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
  output logic                     id_valid_o,
  output logic [ADDR_WIDTH-1:0]    id_pc_o,
  output logic [INST_WIDTH-1:0]    id_inst_o,
  input  logic                     id_ready_i,
  output logic [$clog2(DEPTH):0]   q_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  ifq_state_t            state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] drain_addr;
  logic                  pend;
  logic [CW-1:0]         count;
  entry_t                head;
  entry_t                wentry;
  logic                  empty;
  logic                  done;
  logic                  fetch_done;
  logic                  drain_go;
  logic                  byp;
  logic                  push;
  logic                  pop;

  assign empty = (count == '0);

  // A mid-wait request keeps ic_req high even through a redirect.
  always_comb begin
    ic_req = 1'b0;
    if (rst)
      ic_req = 1'b0;
    else if (state == IFQ_DRAIN)
      ic_req = 1'b1;
    else
      ic_req = pend | ((count != FULL) & ~redirect_i);
  end

  assign ic_addr    = (state == IFQ_DRAIN) ? drain_addr : fetch_pc;
  assign done       = ic_req & ~ic_wait;
  assign fetch_done = done & (state == IFQ_FETCH) & ~redirect_i;
  assign drain_go   = (state == IFQ_FETCH) & redirect_i & pend & ic_wait;

`ifdef IFQ_BYPASS_EN
  assign byp = fetch_done & empty;
`else
  assign byp = 1'b0;
`endif

  assign pop  = ~empty & id_ready_i & ~redirect_i;
  assign push = fetch_done & ~(byp & id_ready_i);

  assign wentry.pc   = fetch_pc;
  assign wentry.inst = ic_rdata;

  always_comb begin
    id_valid_o = 1'b0;
    id_pc_o    = '0;
    id_inst_o  = '0;
    if (!empty) begin
      id_valid_o = 1'b1;
      id_pc_o    = head.pc;
      id_inst_o  = head.inst;
    end else if (byp) begin
      id_valid_o = 1'b1;
      id_pc_o    = fetch_pc;
      id_inst_o  = ic_rdata;
    end
  end

  assign q_count_o = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IFQ_FETCH;
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
      pend       <= 1'b0;
    end else begin
      pend <= ic_req & ic_wait;
      if (redirect_i)
        fetch_pc <= redirect_pc_i;
      else if (fetch_done)
        fetch_pc <= fetch_pc + ADDR_WIDTH'(IFQ_PC_STEP);
      if (drain_go) begin
        state      <= IFQ_DRAIN;
        drain_addr <= fetch_pc;
      end else if (state == IFQ_DRAIN && !ic_wait) begin
        state <= IFQ_FETCH;
      end
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed vector bench for ifetch_queue (DEPTH=4, RESET_PC=0).
// Bypass build (IFQ_BYPASS_EN) runs a dedicated bypass sequence.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_wait;
  logic [31:0] ic_rdata;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_ready_i;
  logic [2:0]  q_count_o;

  int errors = 0;
  int checks = 0;

  ifetch_queue dut (
    .clk           (clk),
    .rst           (rst),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .ic_wait       (ic_wait),
    .ic_rdata      (ic_rdata),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_ready_i    (id_ready_i),
    .q_count_o     (q_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wt;
    logic [31:0] rd;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        val;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  cnt;
  } vec_t;

  function automatic vec_t mk(
    logic wt, logic [31:0] rd, logic rdr, logic [31:0] rpc, logic rdy,
    logic req, logic [31:0] addr, logic val, logic [31:0] pc,
    logic [31:0] inst, logic [2:0] cnt);
    vec_t v;
    v.wt = wt; v.rd = rd; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy;
    v.req = req; v.addr = addr; v.val = val; v.pc = pc;
    v.inst = inst; v.cnt = cnt;
    return v;
  endfunction

  task automatic drv(logic wt, logic [31:0] rd, logic rdr,
                     logic [31:0] rpc, logic rdy);
    ic_wait       = wt;
    ic_rdata      = rd;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
    id_ready_i    = rdy;
  endtask

  task automatic check(string name, logic req, logic [31:0] addr,
                       logic val, logic [31:0] pc, logic [31:0] inst,
                       logic [2:0] cnt);
    checks++;
    if (ic_req !== req || ic_addr !== addr || id_valid_o !== val ||
        id_pc_o !== pc || id_inst_o !== inst || q_count_o !== cnt) begin
      errors++;
      $display("FAIL %s: got req=%b addr=%h val=%b pc=%h inst=%h cnt=%0d, want req=%b addr=%h val=%b pc=%h inst=%h cnt=%0d",
               name, ic_req, ic_addr, id_valid_o, id_pc_o, id_inst_o,
               q_count_o, req, addr, val, pc, inst, cnt);
    end
  endtask

  vec_t vecs [21];

  initial begin
    rst = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    check("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifndef IFQ_BYPASS_EN
    // wt rd rdr rpc rdy | req addr val pc inst cnt
    vecs[0]  = mk(0, 32'h10000000, 0, 0, 1, 1, 32'h0,   0, 32'h0,   32'h0, 0);
    vecs[1]  = mk(0, 32'h10000004, 0, 0, 1, 1, 32'h4,   1, 32'h0,   32'h10000000, 1);
    vecs[2]  = mk(0, 32'h10000008, 0, 0, 1, 1, 32'h8,   1, 32'h4,   32'h10000004, 1);
    vecs[3]  = mk(0, 32'h1000000C, 0, 0, 0, 1, 32'hC,   1, 32'h8,   32'h10000008, 1);
    vecs[4]  = mk(0, 32'h10000010, 0, 0, 0, 1, 32'h10,  1, 32'h8,   32'h10000008, 2);
    vecs[5]  = mk(0, 32'h10000014, 0, 0, 0, 1, 32'h14,  1, 32'h8,   32'h10000008, 3);
    vecs[6]  = mk(0, 32'h0,        0, 0, 0, 0, 32'h18,  1, 32'h8,   32'h10000008, 4);
    vecs[7]  = mk(0, 32'h0,        0, 0, 1, 0, 32'h18,  1, 32'h8,   32'h10000008, 4);
    vecs[8]  = mk(0, 32'h10000018, 0, 0, 0, 1, 32'h18,  1, 32'hC,   32'h1000000C, 3);
    vecs[9]  = mk(0, 32'h0, 1, 32'h100, 1,    0, 32'h1C,  1, 32'hC,   32'h1000000C, 4);
    vecs[10] = mk(0, 32'h10000100, 0, 0, 1, 1, 32'h100, 0, 32'h0,   32'h0, 0);
    vecs[11] = mk(0, 32'h10000104, 0, 0, 1, 1, 32'h104, 1, 32'h100, 32'h10000100, 1);
    vecs[12] = mk(1, 32'h0,        0, 0, 1, 1, 32'h108, 1, 32'h104, 32'h10000104, 1);
    vecs[13] = mk(1, 32'h0, 1, 32'h200, 0,    1, 32'h108, 0, 32'h0,   32'h0, 0);
    vecs[14] = mk(1, 32'h0,        0, 0, 0, 1, 32'h108, 0, 32'h0,   32'h0, 0);
    vecs[15] = mk(0, 32'hDEADBEEF, 0, 0, 0, 1, 32'h108, 0, 32'h0,   32'h0, 0);
    vecs[16] = mk(0, 32'h10000200, 0, 0, 0, 1, 32'h200, 0, 32'h0,   32'h0, 0);
    vecs[17] = mk(1, 32'h0,        0, 0, 0, 1, 32'h204, 1, 32'h200, 32'h10000200, 1);
    vecs[18] = mk(0, 32'hCAFEF00D, 1, 32'hFFFFFFFC, 0,
                  1, 32'h204, 1, 32'h200, 32'h10000200, 1);
    vecs[19] = mk(0, 32'h55550001, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0, 0);
    vecs[20] = mk(1, 32'h0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFFFFFC, 32'h55550001, 1);

    for (int i = 0; i < 21; i++) begin
      if (i != 0) @(negedge clk);
      drv(vecs[i].wt, vecs[i].rd, vecs[i].rdr, vecs[i].rpc, vecs[i].rdy);
      #4;
      check($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].val,
            vecs[i].pc, vecs[i].inst, vecs[i].cnt);
    end

    // Fill to three entries, stall the cache, then reset mid-wait.
    @(negedge clk);
    drv(1'b0, 32'h66660000, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drv(1'b0, 32'h66660004, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drv(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    check("pre_rst", 1'b1, 32'h8, 1'b1, 32'hFFFFFFFC, 32'h55550001, 3'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    drv(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    #4;
    check("post_rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
`else
    drv(1'b0, 32'h12345678, 1'b0, 32'h0, 1'b1);
    #4;
    check("byp_take", 1'b1, 32'h0, 1'b1, 32'h0, 32'h12345678, 3'd0);
    @(negedge clk);
    drv(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
    #4;
    check("byp_gone", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    drv(1'b0, 32'h00009999, 1'b0, 32'h0, 1'b0);
    #4;
    check("byp_hold", 1'b1, 32'h4, 1'b1, 32'h4, 32'h00009999, 3'd0);
    @(negedge clk);
    drv(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    #4;
    check("byp_wr", 1'b1, 32'h8, 1'b1, 32'h4, 32'h00009999, 3'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("post_rst", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
